// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU command codes, control-bus layout,
// forwarding selects, shifter types and the NZCV flag record.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam int CTRL_WB_EN    = 8;
    localparam int CTRL_MEM_R_EN = 7;
    localparam int CTRL_MEM_W_EN = 6;
    localparam int CTRL_CMD_MSB  = 5;
    localparam int CTRL_CMD_LSB  = 2;
    localparam int CTRL_B        = 1;
    localparam int CTRL_S        = 0;

    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // Commands whose C and V come from the adder; all others preserve them.
    function automatic logic is_arith(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_ADC) ||
               (cmd == CMD_SUB) || (cmd == CMD_SBC);
    endfunction

endpackage

// File: rtl/val2_gen.sv
// Second-operand generator: zero-extended memory offset, rotated 8-bit immediate,
// or register operand through the barrel shifter.
module val2_gen
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op_rm,
    input  logic [11:0]     shift_op,
    input  logic            imm,
    input  logic            mem_en,
    output logic [XLEN-1:0] val2
);

    logic [XLEN-1:0]        imm_ext;
    logic [XLEN-1:0]        imm_rot;
    logic [XLEN-1:0]        rm_shf;
    logic signed [XLEN-1:0] rm_s;
    logic [4:0]             rot_amt;
    logic [4:0]             sh_amt;
    shift_t                 sh_type;

    function automatic logic [XLEN-1:0] ror(input logic [XLEN-1:0] x, input logic [4:0] sh);
        if (sh == 5'd0) begin
            return x;
        end
        return (x >> sh) | (x << (XLEN - int'(sh)));
    endfunction

    assign rot_amt = {shift_op[11:8], 1'b0};
    assign sh_amt  = shift_op[11:7];
    assign sh_type = shift_t'(shift_op[6:5]);
    assign imm_ext = {{(XLEN-8){1'b0}}, shift_op[7:0]};
    assign imm_rot = ror(imm_ext, rot_amt);
    assign rm_s    = op_rm;

    always_comb begin
        rm_shf = op_rm;
        case (sh_type)
            SH_LSL:  rm_shf = op_rm << sh_amt;
            SH_LSR:  rm_shf = op_rm >> sh_amt;
            SH_ASR:  rm_shf = rm_s >>> sh_amt;
            SH_ROR:  rm_shf = ror(op_rm, sh_amt);
            default: rm_shf = op_rm;
        endcase
    end

    // Loads/stores always use the raw 12-bit offset, ahead of the immediate flag.
    always_comb begin
        if (mem_en) begin
            val2 = {{(XLEN-12){1'b0}}, shift_op};
        end else if (imm) begin
            val2 = imm_rot;
        end else begin
            val2 = rm_shf;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2, ALU with NZCV, branch target,
// the CPSR flag register and the EXE/MEM pipeline register with freeze.
module exe_stage
    import exe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic [XLEN-1:0]   ID_PC,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic [XLEN-1:0]   Rn,
    input  logic [XLEN-1:0]   Rm,
    input  logic              imm,
    input  logic [11:0]       shiftOp,
    input  logic [23:0]       Signed_imm_24,
    input  logic [3:0]        Dest,
    input  logic [1:0]        fwd_sel1,
    input  logic [1:0]        fwd_sel2,
    input  logic [XLEN-1:0]   mem_fwd_val,
    input  logic [XLEN-1:0]   wb_fwd_val,
    output logic [3:0]        status_out,
    output logic              Branch_taken,
    output logic [XLEN-1:0]   Br_addr,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic              MEM_W_EN_out,
    output logic [XLEN-1:0]   ALU_res_out,
    output logic [XLEN-1:0]   Val_Rm_out,
    output logic [3:0]        Dest_out
);

    logic                   wb_en_p0;
    logic                   mem_r_en_p0;
    logic                   mem_w_en_p0;
    logic                   b_p0;
    logic                   s_p0;
    logic [3:0]             cmd_p0;
    logic [XLEN-1:0]        op1_p0;
    logic [XLEN-1:0]        op_rm_p0;
    logic [XLEN-1:0]        val2_p0;
    logic [XLEN-1:0]        addend_p0;
    logic                   cin_p0;
    logic [XLEN:0]          sum_p0;
    logic [XLEN-1:0]        alu_res_p0;
    logic signed [XLEN-1:0] br_off_p0;
    nzcv_t                  flags_p0;

    nzcv_t                  status_q;

    logic                   wb_en_p1;
    logic                   mem_r_en_p1;
    logic                   mem_w_en_p1;
    logic [XLEN-1:0]        alu_res_p1;
    logic [XLEN-1:0]        val_rm_p1;
    logic [3:0]             dest_p1;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] rf_v,
        input logic [XLEN-1:0] mem_v,
        input logic [XLEN-1:0] wb_v
    );
        case (sel)
            FWD_MEM: return mem_v;
            FWD_WB:  return wb_v;
            default: return rf_v;
        endcase
    endfunction

    // ---- p0: decode, operand select, Val2, ALU ----
    assign wb_en_p0    = ctrl[CTRL_WB_EN];
    assign mem_r_en_p0 = ctrl[CTRL_MEM_R_EN];
    assign mem_w_en_p0 = ctrl[CTRL_MEM_W_EN];
    assign cmd_p0      = ctrl[CTRL_CMD_MSB:CTRL_CMD_LSB];
    assign b_p0        = ctrl[CTRL_B];
    assign s_p0        = ctrl[CTRL_S];

    assign op1_p0   = fwd_mux(fwd_sel1, Rn, mem_fwd_val, wb_fwd_val);
    assign op_rm_p0 = fwd_mux(fwd_sel2, Rm, mem_fwd_val, wb_fwd_val);

    val2_gen #(
        .XLEN (XLEN)
    ) u_val2_gen (
        .op_rm    (op_rm_p0),
        .shift_op (shiftOp),
        .imm      (imm),
        .mem_en   (mem_r_en_p0 | mem_w_en_p0),
        .val2     (val2_p0)
    );

    // Subtraction is an add of the inverted operand; ADC/SBC take C from the register.
    always_comb begin
        addend_p0 = val2_p0;
        cin_p0    = 1'b0;
        case (cmd_p0)
            CMD_ADC: cin_p0 = status_q.c;
            CMD_SUB: begin
                addend_p0 = ~val2_p0;
                cin_p0    = 1'b1;
            end
            CMD_SBC: begin
                addend_p0 = ~val2_p0;
                cin_p0    = status_q.c;
            end
            default: cin_p0 = 1'b0;
        endcase
        sum_p0 = {1'b0, op1_p0} + {1'b0, addend_p0} + {{XLEN{1'b0}}, cin_p0};
    end

    always_comb begin
        alu_res_p0 = '0;
        case (cmd_p0)
            CMD_MOV:                            alu_res_p0 = val2_p0;
            CMD_MVN:                            alu_res_p0 = ~val2_p0;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_res_p0 = sum_p0[XLEN-1:0];
            CMD_AND:                            alu_res_p0 = op1_p0 & val2_p0;
            CMD_ORR:                            alu_res_p0 = op1_p0 | val2_p0;
            CMD_EOR:                            alu_res_p0 = op1_p0 ^ val2_p0;
            default:                            alu_res_p0 = '0;
        endcase
    end

    always_comb begin
        flags_p0.n = alu_res_p0[XLEN-1];
        flags_p0.z = (alu_res_p0 == '0);
        flags_p0.c = status_q.c;
        flags_p0.v = status_q.v;
        if (is_arith(cmd_p0)) begin
            flags_p0.c = sum_p0[XLEN];
            flags_p0.v = (op1_p0[XLEN-1] == addend_p0[XLEN-1]) &&
                         (alu_res_p0[XLEN-1] != op1_p0[XLEN-1]);
        end
    end

    assign br_off_p0    = {{(XLEN-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};
    assign Br_addr      = ID_PC + br_off_p0;
    assign Branch_taken = b_p0;

    // ---- p1: status register and EXE/MEM boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= '0;
        end else if (!freeze && s_p0) begin
            status_q <= flags_p0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en_p1    <= 1'b0;
            mem_r_en_p1 <= 1'b0;
            mem_w_en_p1 <= 1'b0;
            alu_res_p1  <= '0;
            val_rm_p1   <= '0;
            dest_p1     <= '0;
        end else if (!freeze) begin
            wb_en_p1    <= wb_en_p0;
            mem_r_en_p1 <= mem_r_en_p0;
            mem_w_en_p1 <= mem_w_en_p0;
            alu_res_p1  <= alu_res_p0;
            val_rm_p1   <= op_rm_p0;
            dest_p1     <= Dest;
        end
    end

    assign status_out   = status_q;
    assign WB_EN_out    = wb_en_p1;
    assign MEM_R_EN_out = mem_r_en_p1;
    assign MEM_W_EN_out = mem_w_en_p1;
    assign ALU_res_out  = alu_res_p1;
    assign Val_Rm_out   = val_rm_p1;
    assign Dest_out     = dest_p1;

endmodule
